// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the memory port arbiter.
//   - default widths and timeout budget used as parameter defaults
//   - FSM state encoding shared by the top level and anything that decodes it
package arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// arb_timeout_counter: wait-cycle counter for the arbiter's port timeout.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   clr  : restart the count from 0 (asserted on WAIT entry)
//   inc  : count one WAIT cycle
//   hit  : count has reached TIMEOUT
// The count saturates at TIMEOUT so a stuck inc never wraps back to 0.
module arb_timeout_counter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign hit = (count_q == CNT_W'(TIMEOUT));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !hit) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data load/store. Data accesses win over fetch. One transaction at a time:
// grant (IDLE) -> wait for port_ack (IF_WAIT/MEM_WAIT) -> one-cycle
// completion pulse (DONE) -> IDLE.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_req, if_addr               fetch request (level) and PC
//   if_instr, if_valid, if_freeze fetch data, completion pulse, IF stall
//   mem_rd, mem_wr, mem_addr,     data request (level), address, store data
//   mem_wdata
//   mem_rdata, mem_ready,         load data, completion pulse, pipeline stall
//   mem_freeze
//   port_req, port_we, port_addr, shared port request side (registered)
//   port_wdata
//   port_ack, port_rdata          shared port response
//   err                           one-cycle timeout pulse
//
// Build option: define ARB_TIMEOUT_EN to abandon a WAIT after TIMEOUT cycles
// without port_ack; otherwise WAIT states last until ack and err is 0.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_valid,
    output logic              if_freeze,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_freeze,
    output logic              port_req,
    output logic              port_we,
    output logic [ADDR_W-1:0] port_addr,
    output logic [DATA_W-1:0] port_wdata,
    input  logic              port_ack,
    input  logic [DATA_W-1:0] port_rdata,
    output logic              err
);

    arb_state_e        state_q, state_d;
    logic              port_req_q, port_req_d;
    logic              port_we_q, port_we_d;
    logic [ADDR_W-1:0] port_addr_q, port_addr_d;
    logic [DATA_W-1:0] port_wdata_q, port_wdata_d;
    logic              if_valid_q, if_valid_d;
    logic              mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

`ifdef ARB_TIMEOUT_EN
    logic err_q, err_d;
    logic tmo_clr;
    logic tmo_inc;
    logic tmo_hit;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (tmo_clr),
        .inc (tmo_inc),
        .hit (tmo_hit)
    );

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        port_req_d   = port_req_q;
        port_we_d    = port_we_q;
        port_addr_d  = port_addr_q;
        port_wdata_d = port_wdata_q;
        if_valid_d   = 1'b0;
        mem_ready_d  = 1'b0;
        if_instr_d   = if_instr_q;
        mem_rdata_d  = mem_rdata_q;
`ifdef ARB_TIMEOUT_EN
        err_d        = 1'b0;
        tmo_clr      = 1'b0;
        tmo_inc      = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (mem_rd || mem_wr) begin
                    state_d      = ST_MEM_WAIT;
                    port_req_d   = 1'b1;
                    port_we_d    = mem_wr;
                    port_addr_d  = mem_addr;
                    port_wdata_d = mem_wdata;
`ifdef ARB_TIMEOUT_EN
                    tmo_clr      = 1'b1;
`endif
                end else if (if_req) begin
                    state_d      = ST_IF_WAIT;
                    port_req_d   = 1'b1;
                    port_we_d    = 1'b0;
                    port_addr_d  = if_addr;
                    port_wdata_d = '0;
`ifdef ARB_TIMEOUT_EN
                    tmo_clr      = 1'b1;
`endif
                end
            end

            ST_IF_WAIT, ST_MEM_WAIT: begin
`ifdef ARB_TIMEOUT_EN
                tmo_inc = 1'b1;
`endif
                if (port_ack) begin
                    state_d    = ST_DONE;
                    port_req_d = 1'b0;
                    port_we_d  = 1'b0;
                    if (state_q == ST_IF_WAIT) begin
                        if_valid_d = 1'b1;
                        if_instr_d = port_rdata;
                    end else begin
                        mem_ready_d = 1'b1;
                        // Store completions return no data.
                        mem_rdata_d = port_we_q ? '0 : port_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    // Give up: complete the requester with zero data and flag err.
                    state_d    = ST_DONE;
                    port_req_d = 1'b0;
                    port_we_d  = 1'b0;
                    err_d      = 1'b1;
                    if (state_q == ST_IF_WAIT) begin
                        if_valid_d = 1'b1;
                        if_instr_d = '0;
                    end else begin
                        mem_ready_d = 1'b1;
                        mem_rdata_d = '0;
                    end
                end
`endif
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                port_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            port_req_q   <= 1'b0;
            port_we_q    <= 1'b0;
            port_addr_q  <= '0;
            port_wdata_q <= '0;
            if_valid_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            if_instr_q   <= '0;
            mem_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            port_req_q   <= port_req_d;
            port_we_q    <= port_we_d;
            port_addr_q  <= port_addr_d;
            port_wdata_q <= port_wdata_d;
            if_valid_q   <= if_valid_d;
            mem_ready_q  <= mem_ready_d;
            if_instr_q   <= if_instr_d;
            mem_rdata_q  <= mem_rdata_d;
`ifdef ARB_TIMEOUT_EN
            err_q        <= err_d;
`endif
        end
    end

    assign port_req   = port_req_q;
    assign port_we    = port_we_q;
    assign port_addr  = port_addr_q;
    assign port_wdata = port_wdata_q;
    assign if_valid   = if_valid_q;
    assign mem_ready  = mem_ready_q;
    assign if_instr   = if_instr_q;
    assign mem_rdata  = mem_rdata_q;

    assign if_freeze  = if_req & ~if_valid_q;
    assign mem_freeze = (mem_rd | mem_wr) & ~mem_ready_q;

endmodule
